imager_sync_gen: RTL and testbench

Imager power-up sequencer and master sync generator for the image-sensor path. It consumes the one-cycle `imager_rst` pulse produced after PLL lock and drives the sensor's XCLR release sequence. Once the sensor is awake, it generates the active-low XHS/XVS line and frame syncs, an exposure trigger, and frame-start markers. The outputs feed the sensor control pins and the downstream SLVS-EC capture logic in `ImagerSubSystem`.

---
 rtl/imager_sync_gen.sv | 179 +++++++++++++++++
 tb/tb_imager_sync_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imager_sync_gen.sv
// Imager power-up sequencer (XCLR release, wake wait) and master XHS/XVS sync generator.
// Every output is a register loaded from the next-state decode, so syncs line up with h_cnt/v_cnt.
module imager_sync_gen #(
  parameter int H_PERIOD    = 1100,
  parameter int V_PERIOD    = 2250,
  parameter int HS_WIDTH    = 16,
  parameter int VS_LINES    = 1,
  parameter int CLR_CYCLES  = 256,
  parameter int WAKE_CYCLES = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             imager_rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] exposure_lines,
  output logic             XCLR,
  output logic             XHS,
  output logic             XVS,
  output logic             Xtrigger1,
  output logic             new_frame,
  output logic             ready,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_PERIOD - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_PERIOD - 1);
  localparam logic [CNT_W-1:0] V_LEN  = CNT_W'(V_PERIOD);
  localparam logic [CNT_W-1:0] HS_LEN = CNT_W'(HS_WIDTH);
  localparam logic [CNT_W-1:0] VS_LEN = CNT_W'(VS_LINES);
  localparam int SEQ_MAX = (CLR_CYCLES > WAKE_CYCLES) ? CLR_CYCLES : WAKE_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] CLR_LAST  = SEQ_W'(CLR_CYCLES - 1);
  localparam logic [SEQ_W-1:0] WAKE_LAST = SEQ_W'(WAKE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    STANDBY = 3'd2,
    READY   = 3'd3,
    RUN     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [SEQ_W-1:0] seq_cnt, seq_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [CNT_W-1:0] exp_eff, exp_nxt;
  logic [15:0]      frame_nxt;
  logic             start_frame, run_nxt;
  logic             xclr_nxt, xhs_nxt, xvs_nxt, trig_nxt, new_frame_nxt, ready_nxt;

  // A zero exposure still means one line; anything past the frame collapses to line 1.
  function automatic logic [CNT_W-1:0] clamp_exp(input logic [CNT_W-1:0] lines);
    if (lines == '0) begin
      return CNT_W'(1);
    end else if (lines > V_LAST) begin
      return V_LAST;
    end else begin
      return lines;
    end
  endfunction

  // Sequencer next state, raster counters and frame-start shadowing.
  always_comb begin
    state_nxt   = state;
    seq_nxt     = seq_cnt;
    h_nxt       = h_cnt;
    v_nxt       = v_cnt;
    start_frame = 1'b0;
    if (imager_rst) begin
      state_nxt = CLEAR;
      seq_nxt   = '0;
      h_nxt     = '0;
      v_nxt     = '0;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        CLEAR: begin
          if (seq_cnt == CLR_LAST) begin
            state_nxt = STANDBY;
            seq_nxt   = '0;
          end else begin
            seq_nxt = seq_cnt + SEQ_W'(1);
          end
        end
        STANDBY: begin
          if (seq_cnt == WAKE_LAST) begin
            state_nxt = READY;
            seq_nxt   = '0;
          end else begin
            seq_nxt = seq_cnt + SEQ_W'(1);
          end
        end
        READY: begin
          if (enable) begin
            state_nxt   = RUN;
            h_nxt       = '0;
            v_nxt       = '0;
            start_frame = 1'b1;
          end else begin
            state_nxt = READY;
          end
        end
        RUN: begin
          if (h_cnt != H_LAST) begin
            h_nxt = h_cnt + CNT_W'(1);
          end else begin
            h_nxt = '0;
            if (v_cnt != V_LAST) begin
              v_nxt = v_cnt + CNT_W'(1);
            end else begin
              // Frame boundary: either chain straight into the next frame or park in READY.
              v_nxt = '0;
              if (enable) begin
                start_frame = 1'b1;
              end else begin
                state_nxt = READY;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (start_frame) begin
      exp_nxt   = clamp_exp(exposure_lines);
      frame_nxt = frame_cnt + 16'd1;
    end else begin
      exp_nxt   = exp_eff;
      frame_nxt = frame_cnt;
    end
  end

  // Output decode from the next-cycle state and counters.
  always_comb begin
    run_nxt       = (state_nxt == RUN);
    xclr_nxt      = (state_nxt == STANDBY) || (state_nxt == READY) || run_nxt;
    ready_nxt     = (state_nxt == READY) || run_nxt;
    xhs_nxt       = !(run_nxt && (h_nxt < HS_LEN));
    xvs_nxt       = !(run_nxt && (v_nxt < VS_LEN));
    new_frame_nxt = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    trig_nxt      = run_nxt && (v_nxt == (V_LEN - exp_nxt));
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      seq_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      exp_eff   <= CNT_W'(1);
      frame_cnt <= 16'd0;
      XCLR      <= 1'b0;
      XHS       <= 1'b1;
      XVS       <= 1'b1;
      Xtrigger1 <= 1'b0;
      new_frame <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_nxt;
      seq_cnt   <= seq_nxt;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      exp_eff   <= exp_nxt;
      frame_cnt <= frame_nxt;
      XCLR      <= xclr_nxt;
      XHS       <= xhs_nxt;
      XVS       <= xvs_nxt;
      Xtrigger1 <= trig_nxt;
      new_frame <= new_frame_nxt;
      ready     <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_imager_sync_gen.sv
// Bench for imager_sync_gen: directed scenarios plus a random phase, checked every cycle
// against a timestamp/arithmetic model of the power-up sequence and raster.
module tb_imager_sync_gen;

  localparam int H     = 20;
  localparam int V     = 10;
  localparam int HS    = 4;
  localparam int VS    = 2;
  localparam int CLR   = 8;
  localparam int WAKE  = 16;
  localparam int CNT_W = 16;
  localparam int FRAME = H * V;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             imager_rst;
  logic             enable;
  logic [CNT_W-1:0] exposure_lines;
  logic             XCLR, XHS, XVS, Xtrigger1, new_frame, ready;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [15:0]      frame_cnt;

  imager_sync_gen #(
    .H_PERIOD(H), .V_PERIOD(V), .HS_WIDTH(HS), .VS_LINES(VS),
    .CLR_CYCLES(CLR), .WAKE_CYCLES(WAKE), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .imager_rst(imager_rst), .enable(enable),
    .exposure_lines(exposure_lines), .XCLR(XCLR), .XHS(XHS), .XVS(XVS),
    .Xtrigger1(Xtrigger1), .new_frame(new_frame), .ready(ready),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_cnt(frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: cyc = index of the clock period being observed.
  int cyc       = 0;
  int p_rst     = -1;  // period in which the last imager_rst pulse was driven
  bit running   = 1'b0;
  int run_start = 0;   // first RUN period of the current uninterrupted run
  int cur_exp   = 1;   // clamped exposure latched for the frame in progress
  int frames    = 0;

  function automatic int clampf(input int e);
    if (e < 1) return 1;
    if (e > V - 1) return V - 1;
    return e;
  endfunction

  function automatic int model_v();
    return running ? ((cyc - run_start) / H) % V : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    int  pos, e_h, e_v;
    bit  e_xclr, e_rdy, e_xhs, e_xvs, e_trig, e_nf;
    if (running) begin
      pos    = cyc - run_start;
      e_h    = pos % H;
      e_v    = (pos / H) % V;
      e_xclr = 1'b1;
      e_rdy  = 1'b1;
      e_xhs  = (e_h >= HS);
      e_xvs  = (e_v >= VS);
      e_nf   = (pos % FRAME == 0);
      e_trig = (e_v == V - cur_exp);
    end else begin
      e_h = 0; e_v = 0; e_xhs = 1'b1; e_xvs = 1'b1; e_trig = 1'b0; e_nf = 1'b0;
      if (p_rst < 0 || cyc <= p_rst + CLR) begin
        e_xclr = 1'b0; e_rdy = 1'b0;
      end else if (cyc <= p_rst + CLR + WAKE) begin
        e_xclr = 1'b1; e_rdy = 1'b0;
      end else begin
        e_xclr = 1'b1; e_rdy = 1'b1;
      end
    end
    chk("XCLR", 32'(XCLR), 32'(e_xclr));
    chk("ready", 32'(ready), 32'(e_rdy));
    chk("XHS", 32'(XHS), 32'(e_xhs));
    chk("XVS", 32'(XVS), 32'(e_xvs));
    chk("Xtrigger1", 32'(Xtrigger1), 32'(e_trig));
    chk("new_frame", 32'(new_frame), 32'(e_nf));
    chk("h_cnt", 32'(h_cnt), 32'(e_h));
    chk("v_cnt", 32'(v_cnt), 32'(e_v));
    chk("frame_cnt", 32'(frame_cnt), 32'(frames % 65536));
  endtask

  // One clock period: check what the DUT shows, drive this period's inputs, advance the model.
  task automatic cycle(input bit rst_in, input bit en_in, input int exp_in);
    int pos;
    @(negedge sys_clk);
    check_outputs();
    imager_rst     = rst_in;
    enable         = en_in;
    exposure_lines = 16'(exp_in);
    if (!sys_rst) begin
      if (rst_in) begin
        p_rst   = cyc;
        running = 1'b0;
      end else if (running) begin
        pos = cyc - run_start;
        if (pos % FRAME == FRAME - 1) begin
          if (en_in) begin
            frames++;
            cur_exp = clampf(exp_in);
          end else begin
            running = 1'b0;
          end
        end
      end else if (p_rst >= 0 && cyc > p_rst + CLR + WAKE && en_in) begin
        running   = 1'b1;
        run_start = cyc + 1;
        frames++;
        cur_exp   = clampf(exp_in);
      end
    end
    cyc++;
  endtask

  initial begin
    int seg_len, seg_exp;
    bit seg_en;
    sys_rst        = 1'b1;
    imager_rst     = 1'b0;
    enable         = 1'b0;
    exposure_lines = 16'd3;

    // Reset values while sys_rst is held.
    repeat (3) cycle(1'b0, 1'b0, 3);
    sys_rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 3);

    // Power-up: pulse imager_rst and watch CLEAR/STANDBY timing into READY.
    cycle(1'b1, 1'b0, 3);
    repeat (30) cycle(1'b0, 1'b0, 3);
    chk("ready_after_wake", 32'(ready), 32'd1);

    // Sync shape over three frames with exposure 3 (trigger at line 7).
    cycle(1'b0, 1'b1, 3);
    repeat (3 * FRAME) cycle(1'b0, 1'b1, 3);
    chk("frame_cnt_3", 32'(frame_cnt), 32'd3);

    // Exposure drops to 0 mid-frame: this frame keeps line 7, next moves to line 9.
    repeat (100) cycle(1'b0, 1'b1, 3);
    repeat (400) cycle(1'b0, 1'b1, 0);
    // Oversized exposure clamps to line 1.
    repeat (400) cycle(1'b0, 1'b1, 50);

    // Enable drop at v_cnt=4: frame finishes, back to READY, then re-enable.
    for (int i = 0; i < FRAME && model_v() != 4; i++) cycle(1'b0, 1'b1, 3);
    chk("reached_line4", 32'(model_v()), 32'd4);
    repeat (250) cycle(1'b0, 1'b0, 3);
    chk("ready_after_drop", 32'(ready), 32'd1);
    cycle(1'b0, 1'b1, 5);
    repeat (FRAME + 30) cycle(1'b0, 1'b1, 5);

    // Restart mid-frame with enable still high; imager_rst wins and the sequence repeats.
    for (int i = 0; i < FRAME && model_v() != 5; i++) cycle(1'b0, 1'b1, 5);
    chk("reached_line5", 32'(model_v()), 32'd5);
    cycle(1'b1, 1'b1, 5);
    repeat (CLR + WAKE + 60) cycle(1'b0, 1'b1, 5);

    // frame_cnt wrap: park in READY, preload 0xFFFF, start one frame.
    repeat (250) cycle(1'b0, 1'b0, 2);
    force dut.frame_cnt = 16'hFFFF;
    frames = 65535;
    cycle(1'b0, 1'b0, 2);
    release dut.frame_cnt;
    cycle(1'b0, 1'b0, 2);
    cycle(1'b0, 1'b1, 2);
    cycle(1'b0, 1'b1, 2);
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    // Random segments of enable, exposure and occasional restarts.
    for (int s = 0; s < 40; s++) begin
      seg_len = $urandom_range(1, 300);
      seg_en  = ($urandom_range(0, 3) != 0);
      seg_exp = $urandom_range(0, 60);
      if ($urandom_range(0, 19) == 0) cycle(1'b1, seg_en, seg_exp);
      for (int i = 0; i < seg_len; i++) cycle(1'b0, seg_en, seg_exp);
    end
    cycle(1'b0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
